// File: rtl/reg_file_sb.sv
// Integer register file with issue-time scoreboard and a self-clearing reset.
// Ports: clk/rst_n (sync active-low), ready, two read ports rs1/rs2 with
//   data and busy outputs, writeback wr/rd/rd_data, reserve rsv/rsv_rd.
module reg_file_sb #(
    parameter int XLEN   = 32,
    parameter int NREGS  = 32,
    parameter int BYPASS = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    output logic                     ready,
    input  logic [$clog2(NREGS)-1:0] rs1,
    input  logic [$clog2(NREGS)-1:0] rs2,
    output logic [XLEN-1:0]          rs1_data,
    output logic [XLEN-1:0]          rs2_data,
    output logic                     rs1_busy,
    output logic                     rs2_busy,
    input  logic                     wr,
    input  logic [$clog2(NREGS)-1:0] rd,
    input  logic [XLEN-1:0]          rd_data,
    input  logic                     rsv,
    input  logic [$clog2(NREGS)-1:0] rsv_rd
);

    localparam int AW = $clog2(NREGS);

    typedef enum logic {
        CLEAR,
        RUN
    } state_e;

    state_e           state_q;
    logic [AW-1:0]    clr_idx_q;
    logic             ready_q;
    logic [XLEN-1:0]  regs_q [NREGS];
    logic [NREGS-1:0] busy_q;
    logic [NREGS-1:0] busy_d;

    logic run;
    logic wr_en;
    logic rsv_en;
    logic fwd1;
    logic fwd2;

    assign run    = (state_q == RUN);
    assign wr_en  = run && wr && (rd != '0);
    assign rsv_en = run && rsv && (rsv_rd != '0);

    // Set is applied after clear so a new producer reserving the same
    // index as a retiring writeback keeps the register pending.
    always_comb begin
        busy_d = busy_q;
        if (wr_en) begin
            busy_d[rd] = 1'b0;
        end
        if (rsv_en) begin
            busy_d[rsv_rd] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= CLEAR;
            clr_idx_q <= '0;
            ready_q   <= 1'b0;
            busy_q    <= '0;
        end else begin
            busy_q <= busy_d;
            unique case (state_q)
                CLEAR: begin
                    clr_idx_q <= clr_idx_q + AW'(1);
                    if (clr_idx_q == AW'(NREGS - 1)) begin
                        state_q <= RUN;
                        ready_q <= 1'b1;
                    end
                end
                RUN: begin
                    state_q <= RUN;
                end
                default: begin
                    state_q <= CLEAR;
                    ready_q <= 1'b0;
                end
            endcase
        end
    end

    // Storage has no reset of its own; the CLEAR walk zeroes it.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            if (!run) begin
                regs_q[clr_idx_q] <= '0;
            end else if (wr_en) begin
                regs_q[rd] <= rd_data;
            end
        end
    end

    assign fwd1 = (BYPASS != 0) && wr_en && (rd == rs1);
    assign fwd2 = (BYPASS != 0) && wr_en && (rd == rs2);

    assign rs1_data = (!run || rs1 == '0) ? '0 :
                      fwd1 ? rd_data : regs_q[rs1];
    assign rs2_data = (!run || rs2 == '0) ? '0 :
                      fwd2 ? rd_data : regs_q[rs2];

    // busy_q[0] is never set, so x0 reads as not busy.
    assign rs1_busy = run && busy_q[rs1] && !fwd1;
    assign rs2_busy = run && busy_q[rs2] && !fwd2;

    assign ready = ready_q;

endmodule

// File: tb/tb_reg_file_sb.sv
// Directed bench for reg_file_sb with a bypassing and a non-bypassing copy.
// Expected values are queued at drive time and checked at sample time.
module tb_reg_file_sb;

    localparam int XLEN  = 32;
    localparam int NREGS = 32;
    localparam int AW    = 5;

    logic            clk;
    logic            rst_n;
    logic [AW-1:0]   rs1, rs2, rd, rsv_rd;
    logic            wr, rsv;
    logic [XLEN-1:0] rd_data;

    logic            ready_b, ready_n;
    logic [XLEN-1:0] rs1_data_b, rs2_data_b, rs1_data_n, rs2_data_n;
    logic            rs1_busy_b, rs2_busy_b, rs1_busy_n, rs2_busy_n;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string       tag;
        logic [31:0] val;
    } exp_t;

    exp_t sb_q[$];

    reg_file_sb #(.XLEN(XLEN), .NREGS(NREGS), .BYPASS(1)) dut (
        .clk(clk), .rst_n(rst_n), .ready(ready_b),
        .rs1(rs1), .rs2(rs2),
        .rs1_data(rs1_data_b), .rs2_data(rs2_data_b),
        .rs1_busy(rs1_busy_b), .rs2_busy(rs2_busy_b),
        .wr(wr), .rd(rd), .rd_data(rd_data),
        .rsv(rsv), .rsv_rd(rsv_rd)
    );

    reg_file_sb #(.XLEN(XLEN), .NREGS(NREGS), .BYPASS(0)) dut_nb (
        .clk(clk), .rst_n(rst_n), .ready(ready_n),
        .rs1(rs1), .rs2(rs2),
        .rs1_data(rs1_data_n), .rs2_data(rs2_data_n),
        .rs1_busy(rs1_busy_n), .rs2_busy(rs2_busy_n),
        .wr(wr), .rd(rd), .rd_data(rd_data),
        .rsv(rsv), .rsv_rd(rsv_rd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_v(input string tag, input logic [31:0] v);
        exp_t e;
        e.tag = tag;
        e.val = v;
        sb_q.push_back(e);
    endtask

    task automatic observe(input logic [31:0] obs);
        exp_t e;
        checks++;
        if (sb_q.size() == 0) begin
            errors++;
            $error("FAIL sb_empty observed=%h required=entry", obs);
        end else begin
            e = sb_q.pop_front();
            assert (obs === e.val) else begin
                errors++;
                $error("FAIL %s observed=%h required=%h", e.tag, obs, e.val);
            end
        end
    endtask

    task automatic idle();
        wr     = 1'b0;
        rsv    = 1'b0;
        rd     = '0;
        rsv_rd = '0;
    endtask

    // Counts edges from reset release; ready must rise on exactly the 32nd.
    task automatic count_clear(input string tag);
        for (int e = 1; e <= NREGS; e++) begin
            expect_v(tag, {31'd0, e == NREGS});
            expect_v({tag, "_nb"}, {31'd0, e == NREGS});
            tick();
            observe({31'd0, ready_b});
            observe({31'd0, ready_n});
        end
    endtask

    initial begin
        rst_n   = 1'b0;
        rs1     = '0;
        rs2     = '0;
        rd_data = '0;
        idle();
        tick();
        tick();
        expect_v("rst_ready", 32'd0);
        observe({31'd0, ready_b});

        // Traffic during CLEAR must be ignored.
        rst_n   = 1'b1;
        wr      = 1'b1;
        rd      = 5'd4;
        rd_data = 32'hFF;
        rsv     = 1'b1;
        rsv_rd  = 5'd4;
        rs1     = 5'd4;
        rs2     = 5'd4;
        #1;
        expect_v("clr_rs1_data", 32'd0);
        observe(rs1_data_b);
        expect_v("clr_rs1_busy", 32'd0);
        observe({31'd0, rs1_busy_b});
        count_clear("ready_edge");
        idle();
        #1;
        expect_v("clr_x4", 32'd0);
        observe(rs1_data_b);
        expect_v("clr_x4_busy", 32'd0);
        observe({31'd0, rs1_busy_b});

        for (int i = 1; i < NREGS; i++) begin
            rs1 = AW'(i);
            rs2 = AW'(NREGS - i);
            #1;
            expect_v("zero_rs1", 32'd0);
            observe(rs1_data_b);
            expect_v("zero_rs2", 32'd0);
            observe(rs2_data_b);
        end

        // Plain write then read.
        wr      = 1'b1;
        rd      = 5'd5;
        rd_data = 32'hDEADBEEF;
        tick();
        idle();
        rs1 = 5'd5;
        #1;
        expect_v("x5", 32'hDEADBEEF);
        observe(rs1_data_b);
        expect_v("x5_nb", 32'hDEADBEEF);
        observe(rs1_data_n);

        // x0 is hardwired.
        wr      = 1'b1;
        rd      = 5'd0;
        rd_data = 32'h1234;
        rs2     = 5'd0;
        #1;
        expect_v("x0_fwd", 32'd0);
        observe(rs2_data_b);
        tick();
        idle();
        #1;
        expect_v("x0_after", 32'd0);
        observe(rs2_data_b);

        // Forwarding vs. no forwarding with x7 pending.
        wr      = 1'b1;
        rd      = 5'd7;
        rd_data = 32'h11111111;
        tick();
        idle();
        rsv    = 1'b1;
        rsv_rd = 5'd7;
        tick();
        idle();
        wr      = 1'b1;
        rd      = 5'd7;
        rd_data = 32'hA5A5A5A5;
        rs1     = 5'd7;
        #1;
        expect_v("byp_data", 32'hA5A5A5A5);
        observe(rs1_data_b);
        expect_v("byp_busy", 32'd0);
        observe({31'd0, rs1_busy_b});
        expect_v("nobyp_data", 32'h11111111);
        observe(rs1_data_n);
        expect_v("nobyp_busy", 32'd1);
        observe({31'd0, rs1_busy_n});
        tick();
        idle();
        #1;
        expect_v("x7_after", 32'hA5A5A5A5);
        observe(rs1_data_n);
        expect_v("x7_busy_after", 32'd0);
        observe({31'd0, rs1_busy_n});

        // Scoreboard set/clear priority on x3.
        rsv    = 1'b1;
        rsv_rd = 5'd3;
        tick();
        idle();
        rs1 = 5'd3;
        #1;
        expect_v("x3_rsv", 32'd1);
        observe({31'd0, rs1_busy_b});
        rsv     = 1'b1;
        rsv_rd  = 5'd3;
        wr      = 1'b1;
        rd      = 5'd3;
        rd_data = 32'h3333;
        tick();
        idle();
        #1;
        expect_v("x3_set_wins", 32'd1);
        observe({31'd0, rs1_busy_b});
        expect_v("x3_set_wins_nb", 32'd1);
        observe({31'd0, rs1_busy_n});
        wr      = 1'b1;
        rd      = 5'd3;
        rd_data = 32'h4444;
        tick();
        idle();
        #1;
        expect_v("x3_clear", 32'd0);
        observe({31'd0, rs1_busy_b});
        expect_v("x3_data", 32'h4444);
        observe(rs1_data_b);

        // Independent reserve and writeback in one cycle.
        rsv    = 1'b1;
        rsv_rd = 5'd12;
        tick();
        idle();
        rsv     = 1'b1;
        rsv_rd  = 5'd11;
        wr      = 1'b1;
        rd      = 5'd12;
        rd_data = 32'hC;
        tick();
        idle();
        rs1 = 5'd11;
        rs2 = 5'd12;
        #1;
        expect_v("x11_busy", 32'd1);
        observe({31'd0, rs1_busy_b});
        expect_v("x12_busy", 32'd0);
        observe({31'd0, rs2_busy_b});
        expect_v("x12_data", 32'hC);
        observe(rs2_data_b);

        // Reset mid-RUN with x9 written and pending.
        wr      = 1'b1;
        rd      = 5'd9;
        rd_data = 32'h55;
        tick();
        idle();
        rsv    = 1'b1;
        rsv_rd = 5'd9;
        tick();
        idle();
        rs1 = 5'd9;
        #1;
        expect_v("x9_busy_pre", 32'd1);
        observe({31'd0, rs1_busy_b});
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        #1;
        expect_v("rst_run_ready", 32'd0);
        observe({31'd0, ready_b});

        // Reset again partway through CLEAR; full sequence must restart.
        for (int i = 0; i < 10; i++) tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        count_clear("reclear_edge");
        #1;
        expect_v("x9_zero", 32'd0);
        observe(rs1_data_b);
        expect_v("x9_busy_zero", 32'd0);
        observe({31'd0, rs1_busy_b});
        rs2 = 5'd7;
        #1;
        expect_v("x7_zero", 32'd0);
        observe(rs2_data_n);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/reg_file_sb.md
REG_FILE_SB -- requirements
Module: reg_file_sb

Interface
REQ-001 SHALL have parameter XLEN, default 32: register data width in bits.
REQ-002 SHALL have parameter NREGS, default 32: register count; power of two, >= 2; AW = clog2(NREGS).
REQ-003 SHALL have parameter BYPASS, default 1: 1 = same-cycle write-to-read forwarding; 0 = none.
REQ-004 SHALL have port clk  in  1: single clock; all state updates on the rising edge.
REQ-005 SHALL have port rst_n  in  1: reset, synchronous and active-low.
REQ-006 SHALL have port ready  out  1: register file cleared and accepting traffic.
REQ-007 SHALL have ports rs1, rs2  in  AW: read addresses.
REQ-008 SHALL have ports rs1_data, rs2_data  out  XLEN: read data.
REQ-009 SHALL have ports rs1_busy, rs2_busy  out  1: addressed register has a pending write.
REQ-010 SHALL have ports wr  in  1, rd  in  AW, rd_data  in  XLEN: writeback port.
REQ-011 SHALL have ports rsv  in  1, rsv_rd  in  AW: reserve (mark pending) destination at issue.

Function
REQ-012 SHALL implement a two-state FSM, CLEAR and RUN, with internal clear index clr_idx (AW bits).
REQ-013 In CLEAR, each rising edge SHALL write zero to regs[clr_idx] and increment clr_idx.
REQ-014 The edge that clears index NREGS-1 SHALL move the FSM to RUN; ready is registered and SHALL be 1 exactly in RUN.
REQ-015 In CLEAR, wr and rsv SHALL be ignored, and rs1/rs2_data and rs1/rs2_busy SHALL read 0.
REQ-016 Index 0 SHALL be hardwired: reads of address 0 return 0, busy[0] is always 0, and writes/reserves to 0 are dropped.
REQ-017 Reads SHALL be combinational, with zero-cycle latency: rsN_data = regs[rsN].
REQ-018 With BYPASS=1 in RUN, if wr && rd == rsN && rd != 0, rsN_data SHALL equal rd_data in that cycle.
REQ-019 In RUN, wr && rd != 0 SHALL update regs[rd] <= rd_data at the edge, regardless of busy[rd].
REQ-020 The scoreboard SHALL hold NREGS busy bits: rsv && rsv_rd != 0 sets busy[rsv_rd]; wr && rd != 0 clears busy[rd].
REQ-021 If reserve and writeback hit the same index in the same cycle, the set SHALL win, and busy stays 1 for the new producer.
REQ-022 rsN_busy SHALL be busy[rsN], masked to 0 when BYPASS=1 and a same-cycle writeback to rsN != 0 is in progress (data forwarded).
REQ-023 Reserve and writeback to different indices in one cycle SHALL both take effect independently.
REQ-024 With BYPASS=0, a read of rd during its write cycle SHALL return the old value, and busy SHALL stay unmasked.

Reset
REQ-025 rst_n low at an edge SHALL force state = CLEAR, clr_idx = 0, ready = 0, and all busy bits to 0.
REQ-026 Reset asserted mid-RUN or mid-CLEAR SHALL restart the full clear sequence; no partial state survives.
REQ-027 ready SHALL rise on the NREGS-th rising edge after the first edge with rst_n high (32 edges by default).
REQ-028 Register contents SHALL NOT be relied on before ready; after ready, every regs[i] = 0.

Verification
REQ-029 Reset, then count edges: ready = 0 through edge 31 and 1 after edge 32; then read all 31 nonzero addresses -> all 0.
REQ-030 Write wr=1, rd=5, rd_data=0xDEADBEEF; next cycle rs1=5 -> 0xDEADBEEF. Then write rd=0 with 0x1234; rs2=0 -> 0.
REQ-031 BYPASS=1: wr rd=7 data=0xA5A5A5A5 with rs1=7 in the same cycle -> rs1_data=0xA5A5A5A5, rs1_busy=0. Rerun with BYPASS=0 -> old value.
REQ-032 rsv rsv_rd=3 -> rs1=3 busy=1 next cycle; the same cycle with rsv_rd=3 and wr rd=3 -> busy stays 1; wr rd=3 alone -> busy=0 next cycle.
REQ-033 Write x9=0x55 and reserve x9, then pulse rst_n low 1 cycle mid-RUN -> ready = 0 and busy[9] = 0; after 32 edges, x9 reads 0.
REQ-034 During CLEAR, drive wr rd=4 data=0xFF and rsv_rd=4 -> after ready, x4 = 0 and rs1_busy for 4 = 0.
